// File: rtl/main_control_pipe.sv
// main_control_pipe: registered RV32I/RV32A main control with handshake, stall/flush, exceptions and AMO split
module main_control_pipe #(
    parameter int ATOMIC_EN     = 1,
    parameter int AMO_EN        = 1,
    parameter int STRICT_DECODE = 1,
    parameter int CAUSE_W       = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [31:0]        i_instr,
    input  logic               i_stall,
    input  logic               i_flush,
    output logic               o_valid,
    output logic               o_branch,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_mem_to_reg,
    output logic               o_alu_src_b,
    output logic               o_reg_write,
    output logic               o_pc_plus4,
    output logic               o_csr_en,
    output logic               o_atomic,
    output logic [2:0]         o_alu_op,
    output logic [1:0]         o_alu_src_a,
    output logic [1:0]         o_jump,
    output logic               o_ex,
    output logic [CAUSE_W-1:0] o_ex_cause,
    output logic               o_amo_phase
);
    typedef struct packed {
        logic               valid;
        logic               branch;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src_b;
        logic               reg_write;
        logic               pc_plus4;
        logic               csr_en;
        logic               atomic;
        logic [2:0]         alu_op;
        logic [1:0]         alu_src_a;
        logic [1:0]         jump;
        logic               ex;
        logic [CAUSE_W-1:0] ex_cause;
        logic               amo_phase;
    } ctl_t;

    typedef enum logic {IDLE, AMO_WR} state_t;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
        OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_LUI = 7'b0110111,
        OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
        OP_FENCE = 7'b0001111, OP_SYS = 7'b1110011, OP_AMO = 7'b0101111;
    localparam logic [31:0] ECALL = 32'h00000073, EBREAK = 32'h00100073, MRET = 32'h30200073;
    localparam logic STRICT = (STRICT_DECODE != 0);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] f5;
    logic [4:0] rs2;
    logic       bad;
    logic       is_amo;
    logic       accept;
    ctl_t       dec;
    ctl_t       wr;
    ctl_t       q;
    ctl_t       nxt;
    state_t     state_q;
    state_t     state_d;

    assign opc    = i_instr[6:0];
    assign f3     = i_instr[14:12];
    assign f7     = i_instr[31:25];
    assign f5     = i_instr[31:27];
    assign rs2    = i_instr[24:20];
    assign o_ready = !i_stall && state_q == IDLE;
    assign accept = i_valid && o_ready;

    // Decode the incoming instruction; illegal encodings collapse to a cause-2 exception
    always_comb begin
        dec = '0;
        bad = 1'b0;
        is_amo = 1'b0;
        case (opc)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_op = 3'b010;
                bad = STRICT && !(f7 == 7'b0000000 || f7 == 7'b0100000);
            end
            OP_I: begin
                dec.alu_src_b = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op = 3'b011;
            end
            OP_LOAD: begin
                dec.mem_read = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.reg_write = 1'b1;
                bad = STRICT && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src_b = 1'b1;
                bad = STRICT && f3 > 3'b010;
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                dec.alu_op = 3'b001;
                bad = STRICT && (f3 == 3'b010 || f3 == 3'b011);
            end
            OP_LUI: begin
                dec.alu_src_a = 2'd2;
                dec.alu_src_b = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op = 3'b100;
            end
            OP_AUIPC: begin
                dec.alu_src_a = 2'd1;
                dec.alu_src_b = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op = 3'b100;
            end
            OP_JAL: begin
                dec.reg_write = 1'b1;
                dec.jump = 2'd1;
                dec.pc_plus4 = 1'b1;
            end
            OP_JALR: begin
                dec.alu_src_b = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op = 3'b100;
                dec.jump = 2'd2;
                dec.pc_plus4 = 1'b1;
                bad = STRICT && f3 != 3'b000;
            end
            OP_FENCE: dec = '0;
            OP_SYS: begin
                dec.reg_write = i_instr != ECALL && i_instr != EBREAK;
                dec.csr_en = i_instr != ECALL && i_instr != EBREAK;
                dec.ex = i_instr == ECALL || i_instr == EBREAK;
                dec.ex_cause = i_instr == ECALL ? CAUSE_W'(11) : i_instr == EBREAK ? CAUSE_W'(3) : '0;
                bad = STRICT && (f3 == 3'b100 ||
                      (f3 == 3'b000 && i_instr != ECALL && i_instr != EBREAK && i_instr != MRET));
            end
            OP_AMO: begin
                dec.mem_read = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write = 1'b1;
                dec.atomic = 1'b1;
                dec.alu_op = 3'b101;
                dec.mem_write = f5 == 5'b00011;
                is_amo = AMO_EN != 0 && (f5 inside {5'b00000, 5'b00001, 5'b00100, 5'b01000,
                         5'b01100, 5'b10000, 5'b10100, 5'b11000, 5'b11100});
                bad = ATOMIC_EN == 0 || (STRICT && f3 != 3'b010) ||
                      !(f5 == 5'b00010 || f5 == 5'b00011 || is_amo) ||
                      (STRICT && f5 == 5'b00010 && rs2 != 5'd0);
            end
            default: bad = 1'b1;
        endcase
        if (i_instr[1:0] != 2'b11)
            bad = 1'b1;
        if (bad) begin
            dec = '0;
            dec.ex = 1'b1;
            dec.ex_cause = CAUSE_W'(2);
            is_amo = 1'b0;
        end
        dec.valid = 1'b1;
    end

    // Next-state and next-output selection: flush > stall > AMO write phase > accept > bubble
    always_comb begin
        wr = '0;
        wr.valid = 1'b1;
        wr.mem_write = 1'b1;
        wr.atomic = 1'b1;
        wr.alu_op = 3'b101;
        wr.amo_phase = 1'b1;
        nxt = '0;
        state_d = state_q;
        if (i_flush) begin
            state_d = IDLE;
        end else if (i_stall) begin
            nxt = q;
        end else if (state_q == AMO_WR) begin
            nxt = wr;
            state_d = IDLE;
        end else if (accept) begin
            nxt = dec;
            state_d = is_amo ? AMO_WR : IDLE;
        end
    end

    // Output register and FSM state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q <= '0;
            state_q <= IDLE;
        end else begin
            q <= nxt;
            state_q <= state_d;
        end
    end

    assign o_valid      = q.valid;
    assign o_branch     = q.branch;
    assign o_mem_read   = q.mem_read;
    assign o_mem_write  = q.mem_write;
    assign o_mem_to_reg = q.mem_to_reg;
    assign o_alu_src_b  = q.alu_src_b;
    assign o_reg_write  = q.reg_write;
    assign o_pc_plus4   = q.pc_plus4;
    assign o_csr_en     = q.csr_en;
    assign o_atomic     = q.atomic;
    assign o_alu_op     = q.alu_op;
    assign o_alu_src_a  = q.alu_src_a;
    assign o_jump       = q.jump;
    assign o_ex         = q.ex;
    assign o_ex_cause   = q.ex_cause;
    assign o_amo_phase  = q.amo_phase;
endmodule

// File: tb/tb_main_control_pipe.sv
// tb_main_control_pipe: directed-vector self-checking bench for main_control_pipe
module tb_main_control_pipe;
    logic clk = 1'b0;
    logic rst, valid, stall, flush;
    logic [31:0] instr;
    logic rdy, v, br, mr, mw, mtr, sb, rw, pp4, csr, at, ex, ph;
    logic [2:0] op;
    logic [1:0] sa, jp;
    logic [3:0] cause;
    logic rdy0, v0, br0, mr0, mw0, mtr0, sb0, rw0, pp40, csr0, at0, ex0, ph0;
    logic [2:0] op0;
    logic [1:0] sa0, jp0;
    logic [3:0] cause0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    main_control_pipe dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy), .i_instr(instr),
        .i_stall(stall), .i_flush(flush), .o_valid(v), .o_branch(br), .o_mem_read(mr),
        .o_mem_write(mw), .o_mem_to_reg(mtr), .o_alu_src_b(sb), .o_reg_write(rw),
        .o_pc_plus4(pp4), .o_csr_en(csr), .o_atomic(at), .o_alu_op(op), .o_alu_src_a(sa),
        .o_jump(jp), .o_ex(ex), .o_ex_cause(cause), .o_amo_phase(ph)
    );

    main_control_pipe #(.ATOMIC_EN(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy0), .i_instr(instr),
        .i_stall(stall), .i_flush(flush), .o_valid(v0), .o_branch(br0), .o_mem_read(mr0),
        .o_mem_write(mw0), .o_mem_to_reg(mtr0), .o_alu_src_b(sb0), .o_reg_write(rw0),
        .o_pc_plus4(pp40), .o_csr_en(csr0), .o_atomic(at0), .o_alu_op(op0), .o_alu_src_a(sa0),
        .o_jump(jp0), .o_ex(ex0), .o_ex_cause(cause0), .o_amo_phase(ph0)
    );

    // Bit order: valid,branch,mem_read,mem_write,mem_to_reg,src_b,reg_write,pc_plus4,csr_en,atomic,alu_op[3],src_a[2],jump[2],ex,cause[4],amo_phase
    function automatic logic [22:0] ctl(input logic vl, b, r, w, m2r, srcb, regw, p4, ce, a,
                                        input logic [2:0] aop, input logic [1:0] srca, jmp,
                                        input logic e, input logic [3:0] c, input logic p);
        return {vl, b, r, w, m2r, srcb, regw, p4, ce, a, aop, srca, jmp, e, c, p};
    endfunction

    function automatic logic [22:0] obs();
        return {v, br, mr, mw, mtr, sb, rw, pp4, csr, at, op, sa, jp, ex, cause, ph};
    endfunction

    function automatic logic [22:0] obs0();
        return {v0, br0, mr0, mw0, mtr0, sb0, rw0, pp40, csr0, at0, op0, sa0, jp0, ex0, cause0, ph0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [22:0] ZERO   = 23'h0;
    localparam logic [22:0] ADDI   = ctl(1,0,0,0,0,1,1,0,0,0,3'b011,2'd0,2'd0,0,4'd0,0);
    localparam logic [22:0] ECALLC = ctl(1,0,0,0,0,0,0,0,0,0,3'b000,2'd0,2'd0,1,4'd11,0);
    localparam logic [22:0] EBRKC  = ctl(1,0,0,0,0,0,0,0,0,0,3'b000,2'd0,2'd0,1,4'd3,0);
    localparam logic [22:0] ILL    = ctl(1,0,0,0,0,0,0,0,0,0,3'b000,2'd0,2'd0,1,4'd2,0);
    localparam logic [22:0] AMO_RD = ctl(1,0,1,0,1,0,1,0,0,1,3'b101,2'd0,2'd0,0,4'd0,0);
    localparam logic [22:0] AMO_W  = ctl(1,0,0,1,0,0,0,0,0,1,3'b101,2'd0,2'd0,0,4'd0,1);
    localparam logic [22:0] LUI    = ctl(1,0,0,0,0,1,1,0,0,0,3'b100,2'd2,2'd0,0,4'd0,0);
    localparam logic [22:0] JAL    = ctl(1,0,0,0,0,0,1,1,0,0,3'b000,2'd0,2'd1,0,4'd0,0);
    localparam logic [22:0] SW     = ctl(1,0,0,1,0,1,0,0,0,0,3'b000,2'd0,2'd0,0,4'd0,0);
    localparam logic [22:0] SUB    = ctl(1,0,0,0,0,0,1,0,0,0,3'b010,2'd0,2'd0,0,4'd0,0);

    task automatic accept_one(input string tag, input logic [31:0] ins, input logic [22:0] exp);
        valid = 1'b1;
        instr = ins;
        step();
        check(tag, 32'(obs()), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; stall = 1'b0; flush = 1'b0; instr = 32'h0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("reset_outs", 32'(obs()), 32'(ZERO));
        check("reset_ready", 32'(rdy), 32'd1);

        accept_one("addi", 32'h00500093, ADDI);
        accept_one("ecall", 32'h00000073, ECALLC);
        accept_one("ebreak", 32'h00100073, EBRKC);
        accept_one("all_ones", 32'hFFFFFFFF, ILL);
        accept_one("low_bits_00", 32'h00500090, ILL);
        accept_one("lui", 32'h000012B7, LUI);
        accept_one("jal", 32'h0000006F, JAL);
        accept_one("sw", 32'h0020A023, SW);
        accept_one("sub", 32'h40000033, SUB);
        accept_one("load_f3_011", 32'h0000B083, ILL);
        accept_one("r_bad_f7", 32'h02000033, ILL);

        accept_one("amo_c1", 32'h0020A1AF, AMO_RD);
        check("amo_c1_ready", 32'(rdy), 32'd0);
        valid = 1'b0;
        step();
        check("amo_c2", 32'(obs()), 32'(AMO_W));
        check("amo_c2_ready", 32'(rdy), 32'd1);
        step();
        check("amo_c3_bubble", 32'(obs()), 32'(ZERO));

        accept_one("amo_stall_c1", 32'h0020A1AF, AMO_RD);
        valid = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("amo_stall_hold", 32'(obs()), 32'(AMO_RD));
            check("amo_stall_ready", 32'(rdy), 32'd0);
        end
        stall = 1'b0;
        step();
        check("amo_stall_wr", 32'(obs()), 32'(AMO_W));
        step();
        check("amo_stall_after", 32'(obs()), 32'(ZERO));

        accept_one("amo_flush_c1", 32'h0020A1AF, AMO_RD);
        valid = 1'b0;
        flush = 1'b1;
        step();
        check("flush_outs", 32'(obs()), 32'(ZERO));
        check("flush_ready", 32'(rdy), 32'd1);
        flush = 1'b0;
        step();
        check("flush_no_wr", 32'(obs()), 32'(ZERO));

        accept_one("amo_fs_c1", 32'h0020A1AF, AMO_RD);
        valid = 1'b0;
        flush = 1'b1;
        stall = 1'b1;
        step();
        check("flush_stall_outs", 32'(obs()), 32'(ZERO));
        flush = 1'b0;
        stall = 1'b0;
        #1;
        check("flush_stall_ready", 32'(rdy), 32'd1);
        step();
        check("flush_stall_no_wr", 32'(obs()), 32'(ZERO));

        accept_one("lr_atomic", 32'h1000A1AF, AMO_RD);
        check("lr_no_atomic_en", 32'(obs0()), 32'(ILL));
        check("lr_ready", 32'(rdy), 32'd1);
        valid = 1'b0;
        step();
        check("bubble1", 32'(obs()), 32'(ZERO));
        step();
        check("bubble2", 32'(obs()), 32'(ZERO));

        accept_one("pre_rst", 32'h00500093, ADDI);
        valid = 1'b0;
        rst = 1'b1;
        step();
        check("rst_outs", 32'(obs()), 32'(ZERO));
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(rdy), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
